// File: rtl/cpu_consts_pkg.sv
// Shared CPU constants used by the load/store stage and the future cache path.
//   size_e      : access size encoding carried on req_size_i
//   EXC_*       : exception cause codes reported on exc_code_o
//   lsu_state_e : load/store stage FSM states
package cpu_consts;

  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } size_e;

  localparam logic [4:0] EXC_LD_MISALIGN = 5'd4;
  localparam logic [4:0] EXC_LD_FAULT    = 5'd5;
  localparam logic [4:0] EXC_ST_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_ST_FAULT    = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_EXC
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for a single data-memory row.
//   offset     in  : byte index of the access inside the row
//   size       in  : access size
//   zero_extnd in  : 1 = zero-extend loads, 0 = sign-extend
//   wr_data    in  : right-justified store data
//   rd_row     in  : full row returned by memory
//   misaligned out : access crosses its natural alignment
//   be         out : byte enables for the row
//   wr_lane    out : store data steered to its byte lanes
//   rd_ext     out : extracted and extended load data
module lsu_align
  import cpu_consts::*;
#(
  parameter int XLEN = 64,
  localparam int BE_W = XLEN / 8,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [OFF_W-1:0] offset,
  input  size_e            size,
  input  logic             zero_extnd,
  input  logic [XLEN-1:0]  wr_data,
  input  logic [XLEN-1:0]  rd_row,
  output logic             misaligned,
  output logic [BE_W-1:0]  be,
  output logic [XLEN-1:0]  wr_lane,
  output logic [XLEN-1:0]  rd_ext
);

  // Fill everything above bit nbits-1 with zero or with the value's top bit.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input int nbits,
                                             input logic zx);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = nbits; i < XLEN; i++) r[i] = zx ? 1'b0 : v[nbits-1];
    return r;
  endfunction

  logic [OFF_W+2:0] shamt;
  logic [OFF_W-1:0] low_mask;
  logic [7:0]       size_mask;
  logic [XLEN-1:0]  row_shift;

  assign shamt = {offset, 3'b000};

  always_comb begin
    low_mask  = '0;
    size_mask = 8'h01;
    case (size)
      BYTE:        begin low_mask = '0;          size_mask = 8'h01; end
      HALF_WORD:   begin low_mask = OFF_W'(1);   size_mask = 8'h03; end
      WORD:        begin low_mask = OFF_W'(3);   size_mask = 8'h0F; end
      DOUBLE_WORD: begin low_mask = OFF_W'(7);   size_mask = 8'hFF; end
      default:     begin low_mask = '0;          size_mask = 8'h01; end
    endcase
  end

  // A double-word never fits a 32-bit row, whatever its address.
  assign misaligned = (|(offset & low_mask)) | ((size == DOUBLE_WORD) && (XLEN == 32));
  assign be         = BE_W'(size_mask) << offset;
  assign wr_lane    = wr_data << shamt;
  assign row_shift  = rd_row >> shamt;

  always_comb begin
    rd_ext = rd_row;
    case (size)
      BYTE:        rd_ext = extend(row_shift, 8, zero_extnd);
      HALF_WORD:   rd_ext = extend(row_shift, 16, zero_extnd);
      WORD:        rd_ext = extend(row_shift, 32, zero_extnd);
      DOUBLE_WORD: rd_ext = rd_row;
      default:     rd_ext = rd_row;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// Load/store stage between the execute pipeline and data memory.
// Takes one request at a time, checks alignment and the legal address
// window, runs a req/gnt/rvalid transaction with byte enables and lane
// steering, and returns extended load data or a precise exception.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_*                  : pipeline request (valid/ready handshake)
//   resp_valid_o, resp_rd_data_o, exc_* : one-cycle completion
//   mem_*                  : data-memory request/grant/response port
module mem_lsu_stage
  import cpu_consts::*;
#(
  parameter int          XLEN           = 64,
  parameter logic [63:0] MEM_BASE       = 64'd0,
  parameter logic [63:0] MEM_SIZE       = 64'd524288,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic              req_wr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_zero_extnd_i,
  input  logic [XLEN-1:0]   req_wr_data_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rd_data_o,
  output logic              exc_valid_o,
  output logic [4:0]        exc_code_o,
  output logic [XLEN-1:0]   exc_tval_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_wr_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wr_data_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rd_data_i,
  input  logic              mem_err_i
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [64:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [64:0] WIN_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  function automatic logic [4:0] fault_code(input logic wr);
    return wr ? EXC_ST_FAULT : EXC_LD_FAULT;
  endfunction

  function automatic logic [4:0] misalign_code(input logic wr);
    return wr ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
  endfunction

  lsu_state_e       state;
  logic [XLEN-1:0]  cap_addr;
  logic             cap_wr;
  size_e            cap_size;
  logic             cap_zext;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_next;

  logic [OFF_W-1:0] al_offset;
  size_e            al_size;
  logic             al_misaligned;
  logic [BE_W-1:0]  al_be;
  logic [XLEN-1:0]  al_wr_lane;
  logic [XLEN-1:0]  al_rd_ext;
  logic [64:0]      addr_ext;
  logic             in_bounds;

  // The aligner looks at the incoming request while idle and at the
  // captured request for the rest of the transaction.
  assign al_offset = (state == ST_IDLE) ? req_addr_i[OFF_W-1:0] : cap_addr[OFF_W-1:0];
  assign al_size   = (state == ST_IDLE) ? size_e'(req_size_i) : cap_size;

  lsu_align #(.XLEN(XLEN)) u_align (
    .offset     (al_offset),
    .size       (al_size),
    .zero_extnd (cap_zext),
    .wr_data    (req_wr_data_i),
    .rd_row     (mem_rd_data_i),
    .misaligned (al_misaligned),
    .be         (al_be),
    .wr_lane    (al_wr_lane),
    .rd_ext     (al_rd_ext)
  );

  // Bounds are checked on the first byte only, with one spare bit so the
  // window end cannot wrap.
  assign addr_ext    = {1'b0, 64'(req_addr_i)};
  assign in_bounds   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign req_ready_o = (state == ST_IDLE);
  assign tmo_next    = tmo_cnt + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      cap_addr       <= '0;
      cap_wr         <= 1'b0;
      cap_size       <= BYTE;
      cap_zext       <= 1'b0;
      tmo_cnt        <= '0;
      resp_valid_o   <= 1'b0;
      resp_rd_data_o <= '0;
      exc_valid_o    <= 1'b0;
      exc_code_o     <= '0;
      exc_tval_o     <= '0;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= '0;
      mem_wr_o       <= 1'b0;
      mem_be_o       <= '0;
      mem_wr_data_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            cap_addr <= req_addr_i;
            cap_wr   <= req_wr_i;
            cap_size <= size_e'(req_size_i);
            cap_zext <= req_zero_extnd_i;
            if (al_misaligned || !in_bounds) begin
              state <= ST_EXC;
            end else begin
              state         <= ST_ISSUE;
              mem_req_o     <= 1'b1;
              mem_addr_o    <= {req_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
              mem_wr_o      <= req_wr_i;
              mem_be_o      <= al_be;
              mem_wr_data_o <= al_wr_lane;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_gnt_i) begin
            state         <= ST_WAIT;
            tmo_cnt       <= '0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_wr_o      <= 1'b0;
            mem_be_o      <= '0;
            mem_wr_data_o <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            if (mem_err_i) begin
              exc_valid_o <= 1'b1;
              exc_code_o  <= fault_code(cap_wr);
              exc_tval_o  <= cap_addr;
            end else begin
              resp_rd_data_o <= cap_wr ? '0 : al_rd_ext;
            end
          end else begin
            tmo_cnt <= tmo_next;
            if ((TIMEOUT_CYCLES != 0) && (tmo_next == CNT_W'(TIMEOUT_CYCLES))) begin
              state        <= ST_RESP;
              resp_valid_o <= 1'b1;
              exc_valid_o  <= 1'b1;
              exc_code_o   <= fault_code(cap_wr);
              exc_tval_o   <= cap_addr;
            end
          end
        end
        ST_RESP, ST_EXC: begin
          if (resp_valid_o) begin
            state          <= ST_IDLE;
            resp_valid_o   <= 1'b0;
            resp_rd_data_o <= '0;
            exc_valid_o    <= 1'b0;
            exc_code_o     <= '0;
            exc_tval_o     <= '0;
          end else begin
            // Only a rejected request reaches here without a pulse pending;
            // misalignment takes precedence over a bounds fault.
            resp_valid_o <= 1'b1;
            exc_valid_o  <= 1'b1;
            exc_code_o   <= al_misaligned ? misalign_code(cap_wr) : fault_code(cap_wr);
            exc_tval_o   <= cap_addr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed self-checking bench for mem_lsu_stage (XLEN=64, 512 KiB window
// at address 0, watchdog of 8 cycles).
module tb_mem_lsu_stage;
  import cpu_consts::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        req_wr_i;
  logic [1:0]  req_size_i;
  logic        req_zero_extnd_i;
  logic [63:0] req_wr_data_i;
  logic        resp_valid_o;
  logic [63:0] resp_rd_data_o;
  logic        exc_valid_o;
  logic [4:0]  exc_code_o;
  logic [63:0] exc_tval_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [63:0] mem_addr_o;
  logic        mem_wr_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_wr_data_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rd_data_i;
  logic        mem_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_lsu_stage #(
    .XLEN(64), .MEM_BASE(64'd0), .MEM_SIZE(64'd524288), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wr_i(req_wr_i), .req_size_i(req_size_i),
    .req_zero_extnd_i(req_zero_extnd_i), .req_wr_data_i(req_wr_data_i),
    .resp_valid_o(resp_valid_o), .resp_rd_data_o(resp_rd_data_o),
    .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o), .exc_tval_o(exc_tval_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wr_o(mem_wr_o), .mem_be_o(mem_be_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i), .mem_err_i(mem_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns at the next negedge, i.e. in
  // the first cycle after acceptance.
  task automatic accept(input logic [63:0] addr, input logic wr, input logic [1:0] size,
                        input logic zx, input logic [63:0] wd);
    chk("ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_addr_i = addr; req_wr_i = wr;
    req_size_i = size; req_zero_extnd_i = zx; req_wr_data_i = wd;
    @(negedge clk);
    req_valid_i = 1'b0; req_addr_i = '0; req_wr_i = 1'b0;
    req_size_i = '0; req_zero_extnd_i = 1'b0; req_wr_data_i = '0;
  endtask

  // Memory side of one transaction: hold off grant, check the request,
  // grant, then respond in the first WAIT cycle.
  task automatic mem_txn(input logic [63:0] e_addr, input logic [7:0] e_be, input logic e_wr,
                         input logic [63:0] e_wd, input int gnt_wait,
                         input logic [63:0] row, input logic err);
    for (int i = 0; i < gnt_wait; i++) begin
      chk("mem_req_held", 64'(mem_req_o), 64'd1);
      chk("ready_busy", 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    chk("mem_req", 64'(mem_req_o), 64'd1);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_be", 64'(mem_be_o), 64'(e_be));
    chk("mem_wr", 64'(mem_wr_o), 64'(e_wr));
    chk("mem_wdata", mem_wr_data_o, e_wd);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk("mem_req_drop", 64'(mem_req_o), 64'd0);
    chk("resp_early", 64'(resp_valid_o), 64'd0);
    mem_rvalid_i = 1'b1; mem_rd_data_i = row; mem_err_i = err;
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_rd_data_i = '0; mem_err_i = 1'b0;
  endtask

  task automatic chk_resp(input logic e_exc, input logic [4:0] e_code,
                          input logic [63:0] e_tval, input logic [63:0] e_rd);
    chk("resp_valid", 64'(resp_valid_o), 64'd1);
    chk("exc_valid", 64'(exc_valid_o), 64'(e_exc));
    chk("exc_code", 64'(exc_code_o), 64'(e_code));
    chk("exc_tval", exc_tval_o, e_tval);
    chk("rd_data", resp_rd_data_o, e_rd);
    chk("ready_in_resp", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    chk("resp_pulse_end", 64'(resp_valid_o), 64'd0);
    chk("ready_after", 64'(req_ready_o), 64'd1);
  endtask

  // Rejected request: nothing on the memory port, pulse two cycles after accept.
  task automatic exc_path(input logic [4:0] e_code, input logic [63:0] e_tval);
    chk("exc_no_mem_req", 64'(mem_req_o), 64'd0);
    chk("exc_resp_early", 64'(resp_valid_o), 64'd0);
    @(negedge clk);
    chk("exc_no_mem_req2", 64'(mem_req_o), 64'd0);
    chk_resp(1'b1, e_code, e_tval, 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_wr_i = 1'b0;
    req_size_i = '0; req_zero_extnd_i = 1'b0; req_wr_data_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rd_data_i = '0; mem_err_i = 1'b0;
    #3;
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp", 64'(resp_valid_o), 64'd0);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_exc", 64'(exc_valid_o), 64'd0);
    chk("rst_code", 64'(exc_code_o), 64'd0);
    chk("rst_be", 64'(mem_be_o), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // LW 0x1004, sign-extended
    accept(64'h1004, 1'b0, WORD, 1'b0, 64'd0);
    mem_txn(64'h1000, 8'hF0, 1'b0, 64'd0, 0, 64'h8000_0001_0000_0000, 1'b0);
    chk_resp(1'b0, 5'd0, 64'd0, 64'hFFFF_FFFF_8000_0001);

    // LHU / LH 0x22
    accept(64'h22, 1'b0, HALF_WORD, 1'b1, 64'd0);
    mem_txn(64'h20, 8'h0C, 1'b0, 64'd0, 0, 64'h0000_0000_8765_0000, 1'b0);
    chk_resp(1'b0, 5'd0, 64'd0, 64'h0000_0000_0000_8765);
    accept(64'h22, 1'b0, HALF_WORD, 1'b0, 64'd0);
    mem_txn(64'h20, 8'h0C, 1'b0, 64'd0, 0, 64'h0000_0000_8765_0000, 1'b0);
    chk_resp(1'b0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_8765);

    // Misaligned and out-of-window requests
    accept(64'h2003, 1'b1, HALF_WORD, 1'b0, 64'h1234);
    exc_path(5'd6, 64'h2003);
    accept(64'h4, 1'b0, DOUBLE_WORD, 1'b0, 64'd0);
    exc_path(5'd4, 64'h4);
    accept(64'h80002, 1'b0, WORD, 1'b0, 64'd0);
    exc_path(5'd4, 64'h80002);
    accept(64'h80000, 1'b0, BYTE, 1'b0, 64'd0);
    exc_path(5'd5, 64'h80000);
    accept(64'h80000, 1'b1, BYTE, 1'b0, 64'h55);
    exc_path(5'd7, 64'h80000);

    // LB at last legal byte
    accept(64'h7FFFF, 1'b0, BYTE, 1'b0, 64'd0);
    mem_txn(64'h7FFF8, 8'h80, 1'b0, 64'd0, 0, 64'h9A00_0000_0000_0000, 1'b0);
    chk_resp(1'b0, 5'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF9A);

    // SB 0xAB at 0x10, grant held off 4 cycles; store returns zero data
    accept(64'h10, 1'b1, BYTE, 1'b0, 64'h1234_5678_9ABC_DEAB);
    mem_txn(64'h10, 8'h01, 1'b1, 64'h1234_5678_9ABC_DEAB, 4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk_resp(1'b0, 5'd0, 64'd0, 64'd0);

    // SH at 0x1A: lanes 2..3
    accept(64'h1A, 1'b1, HALF_WORD, 1'b0, 64'h1111_2222_3333_BEEF);
    mem_txn(64'h18, 8'h0C, 1'b1, 64'h2222_3333_BEEF_0000, 1, 64'd0, 1'b0);
    chk_resp(1'b0, 5'd0, 64'd0, 64'd0);

    // Bus errors
    accept(64'h40, 1'b1, WORD, 1'b0, 64'hCAFE_F00D);
    mem_txn(64'h40, 8'h0F, 1'b1, 64'hCAFE_F00D, 0, 64'h1234, 1'b1);
    chk_resp(1'b1, 5'd7, 64'h40, 64'd0);
    accept(64'h48, 1'b0, DOUBLE_WORD, 1'b0, 64'd0);
    mem_txn(64'h48, 8'hFF, 1'b0, 64'd0, 0, 64'h5555_5555_5555_5555, 1'b1);
    chk_resp(1'b1, 5'd5, 64'h48, 64'd0);

    // Watchdog: no response for 8 WAIT cycles
    accept(64'h100, 1'b0, DOUBLE_WORD, 1'b0, 64'd0);
    chk("tmo_mem_req", 64'(mem_req_o), 64'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("tmo_wait_quiet", 64'(resp_valid_o), 64'd0);
      @(negedge clk);
    end
    chk_resp(1'b1, 5'd5, 64'h100, 64'd0);
    mem_rvalid_i = 1'b1; mem_rd_data_i = 64'hABCD;
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_rd_data_i = '0;
    chk("stray_rvalid", 64'(resp_valid_o), 64'd0);
    chk("stray_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    chk("stray_rvalid2", 64'(resp_valid_o), 64'd0);

    // Reset during ISSUE drops mem_req_o without a clock edge
    accept(64'h8, 1'b0, DOUBLE_WORD, 1'b0, 64'd0);
    chk("pre_rst_req", 64'(mem_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req_o), 64'd0);
    chk("arst_mem_be", 64'(mem_be_o), 64'd0);
    chk("arst_mem_addr", mem_addr_o, 64'd0);
    chk("arst_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    rst_ni = 1'b1;

    // Reset during WAIT
    accept(64'h30, 1'b0, WORD, 1'b0, 64'd0);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk("wait_ready_low", 64'(req_ready_o), 64'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_wait_ready", 64'(req_ready_o), 64'd1);
    chk("arst_wait_resp", 64'(resp_valid_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // LD 0x8 after reset
    accept(64'h8, 1'b0, DOUBLE_WORD, 1'b0, 64'd0);
    mem_txn(64'h8, 8'hFF, 1'b0, 64'd0, 0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    chk_resp(1'b0, 5'd0, 64'd0, 64'hDEAD_BEEF_0123_4567);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
